mul_div_unit: RTL and testbench

//  - Multi-cycle multiply/divide unit with HI/LO registers; sits in the E stage beside the ALU.
//  - Consumes the forwarded V1_E/V2_E operands from the D->E pipeline register.
//  - Drives busy to the hazard unit. HI/LO feed the AO_E mux for mfhi/mflo into the E->M register.
//  - Models MIPS mult/multu/div/divu/mthi/mtlo with fixed, parameterised latency.

---
 rtl/mul_div_unit.sv | 183 ++++++++++++++++++
 tb/tb_mul_div_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
//   Multi-cycle multiply/divide unit with architectural HI/LO registers.
//   It sits in the E stage beside the ALU. The unit computes the 64-bit
//   result when the operation is accepted and holds it in pend_hi/pend_lo.
//   That result is written to HI/LO after a fixed, parameterised latency.
//
// Parameters
//   MUL_CYCLES  busy cycles for MULT/MULTU (1..15)
//   DIV_CYCLES  busy cycles for DIV/DIVU   (1..15)
//
// Ports
//   clk      in   1   rising-edge clock
//   reset_n  in   1   asynchronous, active-low reset
//   start    in   1   E-stage instruction is an MDU op (qualified by op)
//   op       in   3   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
//   A        in   32  rs operand
//   B        in   32  rt operand
//   flush    in   1   only when MDU_FLUSH_EN is defined: abort an op in flight
//   busy     out  1   high while an operation is in flight
//   HI       out  32  HI register
//   LO       out  32  LO register
//
// Optional feature macro: MDU_FLUSH_EN (adds the flush port).
//
// Handshake: start/op/A/B are sampled at a rising edge only while busy is 0.
// Any start sampled while busy is 1 is ignored; the hazard unit stalls
// instead. A sampled MULT/DIV raises busy for exactly N cycles. HI/LO
// update at the same edge where busy falls.
// ---------------------------------------------------------------------------
module mul_div_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
`ifdef MDU_FLUSH_EN
    input  logic        flush,
`endif
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [3:0] MUL_CNT = 4'(MUL_CYCLES);
    localparam logic [3:0] DIV_CNT = 4'(DIV_CYCLES);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [31:0] pend_hi, pend_hi_n;
    logic [31:0] pend_lo, pend_lo_n;
    logic [31:0] hi_n, lo_n;
    logic        flush_i;

`ifdef MDU_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Datapath: the full result is formed from the operands present at the
    // accepting edge. Later operand changes therefore cannot disturb it.
    // ------------------------------------------------------------------
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] quo_s, rem_s;
    logic        [31:0] quo_u, rem_u;
    logic        [63:0] result;     // {hi, lo}

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'b0, A} * {32'b0, B};
    // SV '/' and '%' truncate toward zero; the remainder follows the dividend.
    assign quo_s  = $signed(A) / $signed(B);
    assign rem_s  = $signed(A) % $signed(B);
    assign quo_u  = A / B;
    assign rem_u  = A % B;

    always_comb begin
        result = 64'b0;
        case (op)
            OP_MULT:  result = prod_s;
            OP_MULTU: result = prod_u;
            OP_DIV: begin
                if (B == 32'b0)
                    result = {A, 32'hFFFF_FFFF};
                else if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF)
                    // Quotient overflow: the result wraps to the dividend.
                    result = {32'h0, 32'h8000_0000};
                else
                    result = {rem_s, quo_s};
            end
            OP_DIVU: begin
                if (B == 32'b0)
                    result = {A, 32'hFFFF_FFFF};
                else
                    result = {rem_u, quo_u};
            end
            default: result = 64'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: next-state and register updates
    // ------------------------------------------------------------------
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        pend_hi_n = pend_hi;
        pend_lo_n = pend_lo;
        hi_n      = HI;
        lo_n      = LO;
        case (state)
            IDLE: begin
                if (start && !flush_i) begin
                    case (op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            pend_hi_n = result[63:32];
                            pend_lo_n = result[31:0];
                            cnt_n     = op[1] ? DIV_CNT : MUL_CNT;
                            state_n   = RUN;
                        end
                        OP_MTHI: hi_n = A;
                        OP_MTLO: lo_n = A;
                        default: ;  // reserved encodings: no state change
                    endcase
                end
            end
            RUN: begin
                if (flush_i) begin
                    state_n = IDLE;
                    cnt_n   = 4'd0;
                end else if (cnt == 4'd1) begin
                    hi_n    = pend_hi;
                    lo_n    = pend_lo;
                    state_n = IDLE;
                    cnt_n   = 4'd0;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            pend_hi <= 32'b0;
            pend_lo <= 32'b0;
            HI      <= 32'b0;
            LO      <= 32'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            pend_hi <= pend_hi_n;
            pend_lo <= pend_lo_n;
            HI      <= hi_n;
            LO      <= lo_n;
        end
    end

    // state is a flop, so busy is a registered output.
    assign busy = (state == RUN);

endmodule

// File: tb/tb_mul_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mul_div_unit
//   Directed bench for mul_div_unit. Each issued MULT/DIV pushes its
//   expected {HI,LO} and busy length. A monitor pops those entries when
//   busy falls and compares them.
// ---------------------------------------------------------------------------
module tb_mul_div_unit;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        flush;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];
    int          len_q[$];

    // Expected architectural HI/LO, tracked by the bench.
    logic [31:0] model_hi, model_lo;

    mul_div_unit #(
        .MUL_CYCLES(MUL_N),
        .DIV_CYCLES(DIV_N)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .op     (op),
        .A      (A),
        .B      (B),
`ifdef MDU_FLUSH_EN
        .flush  (flush),
`endif
        .busy   (busy),
        .HI     (HI),
        .LO     (LO)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic prev_busy = 1'b0;
    int   run_len   = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_busy = 1'b0;
            run_len   = 0;
        end else begin
            if (busy) begin
                run_len++;
            end else if (prev_busy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_completion: HI/LO %h%h with no expectation", HI, LO);
                end else begin
                    check64("busy_len", 64'(run_len), 64'(len_q.pop_front()));
                    check64("hi_lo", {HI, LO}, exp_q.pop_front());
                end
                run_len = 0;
            end
            prev_busy = busy;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        @(negedge clk);
        start = 1'b0;
        // Operand garbage after the accepting edge must not affect results.
        A     = $urandom;
        B     = $urandom;
        op    = 3'($urandom_range(0, 7));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL wait_idle: busy still 1 after %0d cycles, expected 0", n);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo);
        exp_q.push_back({ehi, elo});
        len_q.push_back(o[1] ? DIV_N : MUL_N);
        model_hi = ehi;
        model_lo = elo;
        pulse(o, a, b);
        wait_idle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        op       = 3'd0;
        A        = 32'hDEAD_BEEF;
        B        = 32'hCAFE_F00D;
        flush    = 1'b0;
        model_hi = 32'h0;
        model_lo = 32'h0;
        #1;
        check64("reset_state", {31'b0, busy, HI, LO}, 96'h0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Multiply vectors
        issue(3'd0, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA);
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        issue(3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        issue(3'd0, 32'd7,        32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'hFFFF_FFC8);
        // Divide vectors
        issue(3'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue(3'd2, 32'd7,        32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        issue(3'd3, 32'd100,      32'd0,        32'd100,       32'hFFFF_FFFF);
        issue(3'd2, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        issue(3'd3, 32'hFFFF_FFFF, 32'd10,       32'h0000_0005, 32'h1999_9999);

        // MTHI in IDLE: HI written next edge, busy stays 0, LO untouched
        pulse(3'd4, 32'h0000_1234, 32'h0);
        model_hi = 32'h0000_1234;
        check64("mthi", {31'b0, busy, HI, LO}, {32'b0, model_hi, model_lo});
        // MTLO
        pulse(3'd5, 32'hA5A5_0F0F, 32'h0);
        model_lo = 32'hA5A5_0F0F;
        check64("mtlo", {31'b0, busy, HI, LO}, {32'b0, model_hi, model_lo});
        // Reserved op: no change
        pulse(3'd6, 32'h1111_1111, 32'h2222_2222);
        check64("reserved6", {31'b0, busy, HI, LO}, {32'b0, model_hi, model_lo});
        pulse(3'd7, 32'h3333_3333, 32'h4444_4444);
        check64("reserved7", {31'b0, busy, HI, LO}, {32'b0, model_hi, model_lo});

        // Starts during RUN are ignored
        exp_q.push_back({32'h0, 32'd15});
        len_q.push_back(MUL_N);
        pulse(3'd0, 32'd3, 32'd5);
        pulse(3'd0, 32'd100, 32'd100);
        pulse(3'd4, 32'h7777_7777, 32'h0);
        check64("hold_while_busy", {31'b0, busy, HI, LO}, {32'b1, model_hi, model_lo});
        wait_idle();
        model_hi = 32'h0;
        model_lo = 32'd15;
        @(negedge clk);
        check64("after_ignored", {31'b0, busy, HI, LO}, {32'b0, model_hi, model_lo});

`ifdef MDU_FLUSH_EN
        // Flush at busy cycle 3: three busy cycles, HI/LO unchanged
        exp_q.push_back({model_hi, model_lo});
        len_q.push_back(3);
        pulse(3'd2, 32'd50, 32'd7);     // now in busy cycle 1
        @(negedge clk);                  // busy cycle 2
        @(negedge clk);                  // busy cycle 3
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check64("flush_run", {31'b0, busy, HI, LO}, {32'b0, model_hi, model_lo});
        // Flush with start in IDLE: start ignored
        @(negedge clk);
        flush = 1'b1;
        pulse(3'd4, 32'h9999_9999, 32'h0);
        flush = 1'b0;
        check64("flush_idle", {31'b0, busy, HI, LO}, {32'b0, model_hi, model_lo});
`endif

        // Reset during DIV at busy cycle 4: immediate clear, no late commit
        pulse(3'd2, 32'd1000, 32'd3);   // busy cycle 1
        repeat (3) @(negedge clk);      // busy cycle 4
        #2;
        reset_n = 1'b0;
        #1;
        check64("async_reset", {31'b0, busy, HI, LO}, 96'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_hi = 32'h0;
        model_lo = 32'h0;
        repeat (15) @(negedge clk);
        check64("no_late_commit", {31'b0, busy, HI, LO}, 96'h0);

        repeat (2) @(negedge clk);
        check64("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
